// File: rtl/ascon_pack.sv
// Shared Ascon definitions for the inverse linear-layer datapath.
// Holds the 320-bit state type, the FSM type of pl_inv_iter, the forward
// pl rotation pairs and the inverse rotation table ROT_INV used by the
// squaring steps of p^63 = p^32 * p^16 * p^8 * p^4 * p^2 * p.
package ascon_pack;

  // Five 64-bit words; word 0 (bits [63:0]) is x0.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_pl_inv_fsm;

  localparam int NB_WORDS    = 5;
  localparam int PL_NB_STEPS = 6;

  // Forward pl rotation pair (a, b) per word.
  localparam logic [5:0] PL_ROT [0:4][0:1] = '{
    '{6'd19, 6'd28},
    '{6'd61, 6'd39},
    '{6'd1,  6'd6 },
    '{6'd10, 6'd17},
    '{6'd7,  6'd41}
  };

  // ROT_INV[word][k] = {(a*2^k) mod 64, (b*2^k) mod 64}.
  // An entry of 0 is a genuine rotation by zero: the operand equals x.
  localparam logic [5:0] ROT_INV [0:4][0:5][0:1] = '{
    '{'{6'd19, 6'd28}, '{6'd38, 6'd56}, '{6'd12, 6'd48},
      '{6'd24, 6'd32}, '{6'd48, 6'd0 }, '{6'd32, 6'd0 }},
    '{'{6'd61, 6'd39}, '{6'd58, 6'd14}, '{6'd52, 6'd28},
      '{6'd40, 6'd56}, '{6'd16, 6'd48}, '{6'd32, 6'd32}},
    '{'{6'd1,  6'd6 }, '{6'd2,  6'd12}, '{6'd4,  6'd24},
      '{6'd8,  6'd48}, '{6'd16, 6'd32}, '{6'd32, 6'd0 }},
    '{'{6'd10, 6'd17}, '{6'd20, 6'd34}, '{6'd40, 6'd4 },
      '{6'd16, 6'd8 }, '{6'd32, 6'd16}, '{6'd0,  6'd32}},
    '{'{6'd7,  6'd41}, '{6'd14, 6'd18}, '{6'd28, 6'd36},
      '{6'd56, 6'd8 }, '{6'd48, 6'd16}, '{6'd32, 6'd32}}
  };

  // Rotate a 64-bit word right; n = 0 returns the word unchanged.
  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
    logic [6:0] left_amt;
    left_amt = 7'd64 - {1'b0, n};
    return (x >> n) | (x << left_amt);
  endfunction

  // Forward linear layer pl on all five words.
  function automatic type_state pl_fwd(input type_state s);
    type_state r;
    r = '0;
    for (int w = 0; w < NB_WORDS; w++) begin
      r[w] = s[w] ^ ror64(s[w], PL_ROT[w][0]) ^ ror64(s[w], PL_ROT[w][1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/pl_inv_iter_step.sv
// Combinational squaring step k of the inverse linear layer:
// x ^ ror(x, ROT_INV[w][k][0]) ^ ror(x, ROT_INV[w][k][1]) on each word.
module pl_inv_step
  import ascon_pack::*;
(
  input  type_state  i_state,
  input  logic [2:0] i_step,
  output type_state  o_state
);

  logic [2:0] w_k;

  // Keep the table index inside the six defined steps.
  always_comb begin
    if (i_step > 3'd5) begin
      w_k = 3'd5;
    end else begin
      w_k = i_step;
    end
  end

  // Apply the selected step to every word; zero rotations are not special-cased.
  always_comb begin
    o_state = '0;
    for (int w = 0; w < NB_WORDS; w++) begin
      o_state[w] = i_state[w]
                 ^ ror64(i_state[w], ROT_INV[w][w_k][0])
                 ^ ror64(i_state[w], ROT_INV[w][w_k][1]);
    end
  end

endmodule

// File: rtl/pl_inv_iter.sv
// Iterative inverse of the Ascon linear layer pl on a 320-bit state.
// One squaring step per RUN cycle, six steps in total, result held in DONE
// until the consumer takes it.
// Optional feature macro: PL_INV_SELFCHECK_EN (adds a forward-pl self-check
// against a copy of the loaded input and the check_err_o port).
module pl_inv_iter
  import ascon_pack::*;
#(
  parameter int NB_STEPS = 6
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  type_state state_i,
  output logic      valid_o,
  input  logic      ready_i,
  output type_state state_o,
  output logic      busy_o
`ifdef PL_INV_SELFCHECK_EN
  ,
  output logic      check_err_o
`endif
);

  localparam logic [2:0] LAST_STEP = 3'(NB_STEPS - 1);

  type_pl_inv_fsm r_fsm;
  type_pl_inv_fsm w_fsm_nxt;
  logic [2:0]     r_cnt;
  logic [2:0]     w_cnt_nxt;
  type_state      r_state;
  type_state      w_state_nxt;
  type_state      w_step;
  logic           r_valid;
  logic           r_ready;
  logic           r_busy;
  logic           w_accept;
  logic           w_last;

  pl_inv_step u_step (
    .i_state (r_state),
    .i_step  (r_cnt),
    .o_state (w_step)
  );

  assign w_accept = valid_i & r_ready;
  assign w_last   = (r_fsm == RUN) && (r_cnt == LAST_STEP);

  // Next-state logic for FSM, step counter and state register.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    case (r_fsm)
      IDLE: begin
        if (w_accept) begin
          w_fsm_nxt   = RUN;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = state_i;
        end else begin
          w_fsm_nxt = IDLE;
        end
      end
      RUN: begin
        w_state_nxt = w_step;
        if (r_cnt == LAST_STEP) begin
          w_fsm_nxt = DONE;
          w_cnt_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      DONE: begin
        if (ready_i) begin
          w_fsm_nxt = IDLE;
        end else begin
          w_fsm_nxt = DONE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
        w_cnt_nxt = 3'd0;
      end
    endcase
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_cnt   <= 3'd0;
      r_state <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_valid <= (w_fsm_nxt == DONE);
      r_ready <= (w_fsm_nxt == IDLE);
      r_busy  <= (w_fsm_nxt == RUN);
    end
  end

  // Present the result only while it is valid.
  always_comb begin
    if (r_valid) begin
      state_o = r_state;
    end else begin
      state_o = '0;
    end
  end

  assign valid_o = r_valid;
  assign ready_o = r_ready;
  assign busy_o  = r_busy;

`ifdef PL_INV_SELFCHECK_EN
  type_state r_copy;
  logic      r_check_err;
  type_state w_fwd_last;
  type_state w_fwd_done;

  // Re-applying pl to the result must give back the original input.
  assign w_fwd_last = pl_fwd(w_step);
  assign w_fwd_done = pl_fwd(r_state);

  // Input copy and sticky mismatch flag, evaluated as DONE is entered and while in DONE.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_copy      <= '0;
      r_check_err <= 1'b0;
    end else if (w_accept) begin
      r_copy      <= state_i;
      r_check_err <= 1'b0;
    end else if (w_last) begin
      r_check_err <= (w_fwd_last != r_copy);
    end else if (r_fsm == DONE) begin
      r_check_err <= r_check_err | (w_fwd_done != r_copy);
    end else begin
      r_check_err <= r_check_err;
    end
  end

  assign check_err_o = r_check_err;
`endif

endmodule

// File: tb/tb_pl_inv_iter.sv
// Self-checking bench for pl_inv_iter. The reference inverse is pl applied
// 63 times (p^64 = 1), and forward pl is used for round-trip vectors.
module tb_pl_inv_iter;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic         valid_i;
  logic         ready_o;
  logic [319:0] state_i;
  logic         valid_o;
  logic         ready_i;
  logic [319:0] state_o;
  logic         busy_o;
`ifdef PL_INV_SELFCHECK_EN
  logic         check_err_o;
`endif

  int total = 0;
  int bad   = 0;

  pl_inv_iter dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .state_i  (state_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .state_o  (state_o),
    .busy_o   (busy_o)
`ifdef PL_INV_SELFCHECK_EN
    ,
    .check_err_o (check_err_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int pa [5] = '{19, 61, 1, 10, 7};
  int pb [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] pl_model(input logic [319:0] s);
    logic [319:0] r;
    logic [63:0]  x;
    for (int w = 0; w < 5; w++) begin
      x = s[64*w +: 64];
      r[64*w +: 64] = x ^ rotr(x, pa[w]) ^ rotr(x, pb[w]);
    end
    return r;
  endfunction

  function automatic logic [319:0] inv_model(input logic [319:0] s);
    logic [319:0] y;
    y = s;
    for (int i = 0; i < 63; i++) y = pl_model(y);
    return y;
  endfunction

  function automatic logic [319:0] rnd_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept x, walk through the six RUN cycles and check the DONE result.
  task automatic run_vec(input string tag, input logic [319:0] x, input logic [319:0] exp);
    chk({tag, "_ready_idle"}, 320'(ready_o), 320'd1);
    state_i = x;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    state_i = '0;
    chk({tag, "_busy"}, 320'(busy_o), 320'd1);
    chk({tag, "_ready_run"}, 320'(ready_o), 320'd0);
    repeat (5) tick();
    chk({tag, "_valid_early"}, 320'(valid_o), 320'd0);
    tick();
    chk({tag, "_valid"}, 320'(valid_o), 320'd1);
    chk({tag, "_state"}, state_o, exp);
`ifdef PL_INV_SELFCHECK_EN
    chk({tag, "_check_err"}, 320'(check_err_o), 320'd0);
`endif
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 320'(valid_o), 320'd0);
    chk({tag, "_ready_back"}, 320'(ready_o), 320'd1);
  endtask

  logic [319:0] x;
  logic [319:0] y;
  logic [319:0] kat;

  initial begin
    resetb_i = 1'b0;
    valid_i  = 1'b1;
    ready_i  = 1'b0;
    state_i  = rnd_state();
    kat = {64'h2c342330ea6066d3, 64'hb81a49b9cf6483a8, 64'h5f013068e003b533,
           64'h6569aa62e997dbbb, 64'h3404dc14c532069b};

    // Reset held with valid_i high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 320'(valid_o), 320'd0);
      chk("rst_ready", 320'(ready_o), 320'd1);
      chk("rst_state", state_o, 320'd0);
      chk("rst_busy", 320'(busy_o), 320'd0);
    end
    valid_i  = 1'b0;
    resetb_i = 1'b1;
    tick();

    // Fixed points and known round trip.
    run_vec("ones", {320{1'b1}}, {320{1'b1}});
    run_vec("zero", 320'd0, 320'd0);
    run_vec("kat_rt", pl_model(kat), kat);

    // Random vectors against the model and as round trips.
    for (int i = 0; i < 6; i++) begin
      x = rnd_state();
      run_vec("rnd_inv", x, inv_model(x));
      run_vec("rnd_rt", pl_model(x), x);
    end

    // Backpressure in DONE plus an ignored offer.
    x = rnd_state();
    y = rnd_state();
    state_i = x;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 320'(valid_o), 320'd1);
      chk("bp_state", state_o, inv_model(x));
      if (i == 2) begin
        state_i = y;
        valid_i = 1'b1;
      end
      if (i >= 2) chk("bp_ready_done", 320'(ready_o), 320'd0);
      tick();
    end
    chk("bp_state_after", state_o, inv_model(x));
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("bp_idle_valid", 320'(valid_o), 320'd0);
    chk("bp_idle_ready", 320'(ready_o), 320'd1);
    tick();
    valid_i = 1'b0;
    chk("bp_next_busy", 320'(busy_o), 320'd1);
    repeat (5) tick();
    chk("bp_next_early", 320'(valid_o), 320'd0);
    tick();
    chk("bp_next_valid", 320'(valid_o), 320'd1);
    chk("bp_next_state", state_o, inv_model(y));
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;

    // Reset pulse at counter 3.
    x = rnd_state();
    state_i = x;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    resetb_i = 1'b0;
    #1;
    chk("mrst_valid", 320'(valid_o), 320'd0);
    chk("mrst_ready", 320'(ready_o), 320'd1);
    chk("mrst_busy", 320'(busy_o), 320'd0);
    chk("mrst_state", state_o, 320'd0);
    tick();
    resetb_i = 1'b1;
    tick();
    run_vec("post_rst_rt", pl_model(kat), kat);

`ifdef PL_INV_SELFCHECK_EN
    // Corrupt bit 0 of the working state mid-run.
    state_i = pl_model(kat);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    x = dut.r_state;
    force dut.r_state = x ^ 320'd1;
    #1;
    release dut.r_state;
    repeat (3) tick();
    chk("sc_valid", 320'(valid_o), 320'd1);
    chk("sc_err", 320'(check_err_o), 320'd1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    run_vec("sc_clean", pl_model(kat), kat);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
